// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN           default PC / instruction width
//   fetch_state_e  sequencer states (IDLE / WAIT / DRAIN)
//   NOP_INSTR      encoding used for synthetic entries (addi x0, x0, 0)
package fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no request outstanding
    ST_WAIT  = 2'd1,  // one accepted request outstanding
    ST_DRAIN = 2'd2   // outstanding request belongs to a flushed path
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched entries for decode.
// Ports:
//   clk, rst     clock, synchronous active-high reset (storage cleared to 0)
//   clear        drop all entries; wins over a same-cycle push or pop
//   push/push_data  write one entry (ignored when full)
//   pop          remove head entry (ignored when empty)
//   count        number of valid entries (0..DEPTH)
//   not_empty    head entry is valid
//   head         head entry, read straight from registered storage
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [PTR_W:0]   count,
  output logic             not_empty,
  output logic [W-1:0]     head
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && (count != FULL_CNT);
  assign do_pop    = pop && (count != '0);
  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage sitting directly after the PC register.
// Issues one word request at a time to instruction memory, buffers returned
// {pc, instr} pairs for decode, holds the PC while a fetch cannot be issued
// and flushes everything on a taken branch/jump redirect.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc                       current PC
//   redirect                 taken branch/jump this cycle (flush)
//   pc_hold                  1 = PC must not advance this cycle
//   imem_req_valid/ready     request handshake, imem_req_addr = pc
//   imem_resp_valid/data     one response per accepted request
//   id_valid/id_ready        decode handshake on the FIFO head
//   id_pc, id_instr          head entry contents
//   id_misalign              head entry is a misaligned-PC NOP (optional)
//   fsm_state                sequencer state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// imem_req_valid is not sticky: it drops on redirect and the address follows
// pc, so memory must not assume a pending request persists.
//
// Optional build macro FETCH_MISALIGN_CHK_EN: a misaligned pc seen in IDLE
// with buffer space produces a NOP entry flagged id_misalign instead of a
// memory request, and the PC is held until a redirect.
module if_fetch_stage
  import fetch_pkg::*;
#(
  parameter  int XLEN       = fetch_pkg::XLEN,
  parameter  int FIFO_DEPTH = 2,
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  output logic            pc_hold,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic            id_misalign,
`endif
  output fetch_state_e    fsm_state
);

`ifdef FETCH_MISALIGN_CHK_EN
  localparam int MIS_W = 1;
`else
  localparam int MIS_W = 0;
`endif
  localparam int ENTRY_W = 2 * XLEN + MIS_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  fetch_state_e     state, state_nxt;
  logic [XLEN-1:0]  req_pc;
  logic [PTR_W:0]   fifo_count;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic             idle_ok;
  logic             fire;
  logic             resp_push;
  logic             push;
  logic             pop;

  // A new request may only start when nothing is in flight, the buffer has
  // room for its response, and the PC is not being redirected this cycle.
  assign idle_ok = (state == ST_IDLE) && (fifo_count != FULL_CNT) && !redirect && !rst;

  // Responses for the live path only; a redirect in the same cycle kills it.
  assign resp_push = (state == ST_WAIT) && imem_resp_valid && !redirect;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misaligned;
  logic mis_sent;   // NOP entry already queued for the current held PC
  logic mis_push;

  assign misaligned     = |pc[1:0];
  assign mis_push       = idle_ok && misaligned && !mis_sent;
  assign imem_req_valid = idle_ok && !misaligned;
  assign push           = resp_push || mis_push;
  assign push_data      = mis_push ? {pc, XLEN'(NOP_INSTR), 1'b1}
                                   : {req_pc, imem_resp_data, 1'b0};
  assign id_misalign    = head[0];

  always_ff @(posedge clk) begin
    if (rst || redirect) mis_sent <= 1'b0;
    else if (mis_push)   mis_sent <= 1'b1;
  end
`else
  assign imem_req_valid = idle_ok;
  assign push           = resp_push;
  assign push_data      = {req_pc, imem_resp_data};
`endif

  assign imem_req_addr = pc;
  assign fire          = imem_req_valid && imem_req_ready;
  // PC moves only on an accepted fetch or a redirect load; never in reset.
  assign pc_hold       = rst || !(fire || redirect);
  assign pop           = id_valid && id_ready;
  assign id_pc         = head[ENTRY_W-1 -: XLEN];
  assign id_instr      = head[ENTRY_W-XLEN-1 -: XLEN];
  assign fsm_state     = state;

  fetch_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (fifo_count),
    .not_empty (id_valid),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (fire) req_pc <= pc;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fire) state_nxt = ST_WAIT;
      // A response arriving with a redirect still closes the transaction;
      // its data is simply not pushed.
      ST_WAIT: begin
        if (imem_resp_valid)  state_nxt = ST_IDLE;
        else if (redirect)    state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (imem_resp_valid) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        redirect;
  logic        pc_hold;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  fetch_state_e fsm_state;
  logic        mis_obs;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        id_misalign;
  assign mis_obs = id_misalign;
`else
  assign mis_obs = 1'b0;
`endif

  logic [64:0] exp_q[$];   // {pc, instr, misalign}
  int          n_cmp = 0;
  int          n_bad = 0;
  int          fire_cnt = 0;

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .redirect        (redirect),
    .pc_hold         (pc_hold),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_pc           (id_pc),
    .id_instr        (id_instr),
`ifdef FETCH_MISALIGN_CHK_EN
    .id_misalign     (id_misalign),
`endif
    .fsm_state       (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  // ---------------- one cycle + scoreboard ----------------
  // Settle, score a decode handshake against the expected queue, then step
  // to just after the next rising edge.
  task automatic tick();
    logic [64:0] e;
    #1;
    if (imem_req_valid && imem_req_ready) fire_cnt++;
    if (id_valid && id_ready && !redirect && !rst) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: got pc=%h instr=%h, expected no entry", id_pc, id_instr);
      end else begin
        e = exp_q.pop_front();
        if ({id_pc, id_instr, mis_obs} !== e) begin
          n_bad++;
          $display("FAIL sb_entry: got %h/%h/%b expected %h/%h/%b",
                   id_pc, id_instr, mis_obs, e[64:33], e[32:1], e[0]);
        end
      end
    end
    if (redirect || rst) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver: one complete fetch ----------------
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input int lat);
    int waited;
    pc = addr;
    imem_req_ready = 1'b1;
    #1;
    waited = 0;
    while (!imem_req_valid && waited < 8) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (!imem_req_valid) begin
      n_bad++;
      $display("FAIL fetch_timeout: got req_valid=0 after %0d cycles, expected 1", waited);
      imem_req_ready = 1'b0;
      return;
    end
    n_cmp++;
    if (imem_req_addr !== addr || pc_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_fire: got addr=%h hold=%b expected addr=%h hold=0", imem_req_addr, pc_hold, addr);
    end
    tick();
    imem_req_ready = 1'b0;
    for (int i = 1; i < lat; i++) tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    exp_q.push_back({addr, data, 1'b0});
    tick();
    imem_resp_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; pc = 32'h8000; redirect = 1'b0; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = '0; id_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || pc_hold !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ctrl: got req=%b idv=%b hold=%b expected 0/0/1", imem_req_valid, id_valid, pc_hold);
    end
    n_cmp++;
    if (id_pc !== 32'h0 || id_instr !== 32'h0 || fsm_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL reset_data: got pc=%h instr=%h st=%0d expected 0/0/IDLE", id_pc, id_instr, fsm_state);
    end
    rst = 1'b0;
    imem_req_ready = 1'b0;
  endtask

  task automatic test_single_fetch();
    pc = 32'h8000; imem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || pc_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL single_fire: got req=%b hold=%b expected 1/0", imem_req_valid, pc_hold);
    end
    tick();
    imem_req_ready = 1'b0; pc = 32'h8004;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093;
    exp_q.push_back({32'h8000, 32'h0010_0093, 1'b0});
    #1;
    n_cmp++;
    if (id_valid !== 1'b0 || pc_hold !== 1'b1 || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_wait: got idv=%b hold=%b req=%b expected 0/1/0", id_valid, pc_hold, imem_req_valid);
    end
    tick();
    imem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== 32'h8000 || id_instr !== 32'h0010_0093) begin
      n_bad++;
      $display("FAIL single_out: got idv=%b pc=%h instr=%h expected 1/8000/00100093", id_valid, id_pc, id_instr);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    n_cmp++;
    if (id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_pop: got idv=%b expected 0", id_valid);
    end
  endtask

  task automatic test_ready_stall();
    int f0;
    f0 = fire_cnt;
    pc = 32'h8000; imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000 || pc_hold !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_hold: got req=%b addr=%h hold=%b expected 1/8000/1", imem_req_valid, imem_req_addr, pc_hold);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if (pc_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_fire: got hold=%b expected 0", pc_hold);
    end
    tick();
    imem_req_ready = 1'b0; pc = 32'h8004;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_0113;
    exp_q.push_back({32'h8000, 32'h0020_0113, 1'b0});
    tick();
    imem_resp_valid = 1'b0; id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    n_cmp++;
    if (fire_cnt - f0 != 1) begin
      n_bad++;
      $display("FAIL stall_fires: got %0d fires expected 1", fire_cnt - f0);
    end
  endtask

  task automatic test_fifo_full();
    id_ready = 1'b0;
    fetch_one(32'h8000, 32'h1111_0001, 1);
    fetch_one(32'h8004, 32'h2222_0002, 2);
    pc = 32'h8008; imem_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b0 || pc_hold !== 1'b1 || id_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL full_gate: got req=%b hold=%b idv=%b expected 0/1/1", imem_req_valid, pc_hold, id_valid);
      end
      tick();
    end
    imem_req_ready = 1'b0; id_ready = 1'b1;
    tick(); tick();
    id_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL full_drain: got left=%0d idv=%b expected 0/0", exp_q.size(), id_valid);
    end
    fetch_one(32'h8008, 32'h3333_0003, 3);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    pc = 32'h8000; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; redirect = 1'b1;
    #1;
    n_cmp++;
    if (pc_hold !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_cycle: got hold=%b req=%b expected 0/0", pc_hold, imem_req_valid);
    end
    tick();
    redirect = 1'b0; pc = 32'h9000; imem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if (fsm_state !== ST_DRAIN || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_drain: got st=%0d req=%b expected DRAIN/0", fsm_state, imem_req_valid);
    end
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0; imem_req_ready = 1'b0;
    #1;
    n_cmp++;
    if (id_valid !== 1'b0 || fsm_state !== ST_IDLE || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h9000) begin
      n_bad++;
      $display("FAIL redir_after: got idv=%b st=%0d req=%b addr=%h expected 0/IDLE/1/9000",
               id_valid, fsm_state, imem_req_valid, imem_req_addr);
    end
    id_ready = 1'b1;
    fetch_one(32'h9000, 32'h0000_0513, 1);
    tick();
    id_ready = 1'b0;
  endtask

  task automatic test_redirect_full();
    // pending entry + response arriving together with a redirect
    id_ready = 1'b0;
    fetch_one(32'hA000, 32'hAAAA_0001, 1);
    pc = 32'hA004; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hAAAA_0002; id_ready = 1'b1;
    tick();
    redirect = 1'b0; imem_resp_valid = 1'b0; id_ready = 1'b0;
    #1;
    n_cmp++;
    if (id_valid !== 1'b0 || fsm_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL redir_resp: got idv=%b st=%0d expected 0/IDLE", id_valid, fsm_state);
    end
    // full buffer flushed while decode is consuming
    fetch_one(32'hB000, 32'hBBBB_0001, 1);
    fetch_one(32'hB004, 32'hBBBB_0002, 2);
    redirect = 1'b1; id_ready = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hBBBB_0003;
    tick();
    redirect = 1'b0; id_ready = 1'b0; imem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (id_valid !== 1'b0 || fsm_state !== ST_IDLE || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL redir_full: got idv=%b st=%0d q=%0d expected 0/IDLE/0", id_valid, fsm_state, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++)
      fetch_one(32'hC000 + 32'(4 * i), $urandom, $urandom_range(1, 3));
    tick(); tick();
    id_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drain: got left=%0d idv=%b expected 0/0", exp_q.size(), id_valid);
    end
  endtask

  task automatic test_reset_mid();
    pc = 32'hD000; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; rst = 1'b1; redirect = 1'b1;
    #1;
    n_cmp++;
    if (pc_hold !== 1'b1 || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid: got hold=%b req=%b expected 1/0", pc_hold, imem_req_valid);
    end
    tick();
    rst = 1'b0; redirect = 1'b0;
    #1;
    n_cmp++;
    if (fsm_state !== ST_IDLE || id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_after: got st=%0d idv=%b expected IDLE/0", fsm_state, id_valid);
    end
  endtask

`ifdef FETCH_MISALIGN_CHK_EN
  task automatic test_misalign();
    pc = 32'h8002; imem_req_ready = 1'b1; id_ready = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0 || pc_hold !== 1'b1) begin
      n_bad++;
      $display("FAIL mis_req: got req=%b hold=%b expected 0/1", imem_req_valid, pc_hold);
    end
    exp_q.push_back({32'h8002, 32'h0000_0013, 1'b1});
    tick();
    n_cmp++;
    if (id_valid !== 1'b1 || id_misalign !== 1'b1 || id_instr !== 32'h13 || pc_hold !== 1'b1) begin
      n_bad++;
      $display("FAIL mis_entry: got idv=%b mis=%b instr=%h hold=%b expected 1/1/13/1",
               id_valid, id_misalign, id_instr, pc_hold);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    tick();
    n_cmp++;
    if (id_valid !== 1'b0 || pc_hold !== 1'b1 || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mis_hold: got idv=%b hold=%b req=%b expected 0/1/0", id_valid, pc_hold, imem_req_valid);
    end
    redirect = 1'b1; imem_req_ready = 1'b0;
    tick();
    redirect = 1'b0; pc = 32'h8000;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_fetch();
    test_ready_stall();
    test_fifo_full();
    test_redirect_wait();
    test_redirect_full();
    test_back_to_back();
    test_reset_mid();
`ifdef FETCH_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
